cache_stage1_ctrl: RTL and testbench
====================================

// Module: cache_stage1_ctrl
// PURPOSE
//  Parametrised front (stage-1) controller of the pipelined N-way write-back cache.
//  - Captures UFP requests into the stage register.
//  - Selects a tree-PLRU victim and installs DFP fill lines into it.
//  - Performs byte-masked store-hit writes into data/tag/valid arrays.
//  - Inserts a recovery bubble after every array write.
//  Sits between the UFP port and the SRAM arrays; stage 2 (tag compare) drives miss/store_hit.
// PARAMETERS
//  WAYS        4    ways per set; power of 2, >= 2
//  SETS        16   sets; power of 2
//  LINE_BYTES  32   bytes per line; power of 2, >= 4
//  ADDR_W      32   address width
//  derived: OFF_W=$clog2(LINE_BYTES), SET_W=$clog2(SETS), TAG_W=ADDR_W-SET_W-OFF_W, WAY_W=$clog2(WAYS)
// PORTS
//  clk          in   1               clock, all state on rising edge
//  rst          in   1               asynchronous, active-low reset (rst==0 resets)
//  ufp_addr     in   ADDR_W          request address
//  ufp_rmask    in   4               read byte mask; 0 = no read
//  ufp_wmask    in   4               write byte mask; 0 = no write
//  ufp_wdata    in   32              write data
//  req_ready    out  1               1 = request captured this cycle
//  plru_bits    in   WAYS-1          tree-PLRU state of the current set, heap order
//  miss         in   1               stage 2: stage_reg request missed
//  store_hit    in   1               stage 2: stage_reg store hit in hit_way
//  hit_way      in   WAY_W           hitting way
//  dfp_rdata    in   8*LINE_BYTES    fill line
//  dfp_resp     in   1               fill line valid (one-cycle pulse)
//  web          out  WAYS            per-way array write enable, active-low
//  data_in      out  WAYS x 8*LB     per-way line write data
//  tag_in       out  WAYS x TAG_W    per-way tag write data
//  valid_in     out  WAYS            per-way valid write data
//  data_wmask   out  LINE_BYTES      byte write mask, shared across ways
//  victim_way   out  WAY_W           latched fill victim
//  write_done   out  1               pulse: store write performed
//  stage_reg    out  stage_reg_t     registered request (addr, tag, set, offset, rmask, wmask, wdata)
// BEHAVIOUR
//  Reset (async, rst==0)
//   - state=RUN, stage_reg='0, victim_way=0.
//   - web all 1, data_in/tag_in/valid_in 0, data_wmask all 1, write_done 0.
//  FSM states: RUN, FILL, STORE, BUBBLE. Outputs are combinational from state and inputs.
//  RUN
//   - miss: go FILL, latch victim_way from plru_bits, hold stage_reg.
//   - else store_hit: go STORE, hold stage_reg.
//   - else: req_ready=1, capture the UFP request (zero masks capture an idle request).
//   - miss has priority over store_hit.
//  Victim decode, tree-PLRU
//   - Start at node 0; bit==1 selects lower child 2i+1, bit==0 selects upper child 2i+2.
//   - Leaf index gives the way. WAYS=4 example: plru_bits=3'b011 -> way 0; 3'b100 -> way 2.
//  FILL
//   - Wait for dfp_resp; hold stage_reg; req_ready=0.
//   - On dfp_resp: web[victim_way]=0, data_in=dfp_rdata, tag_in=stage_reg.tag, valid_in=1, data_wmask all 1; go BUBBLE.
//   - dfp_resp in any other state is ignored.
//  STORE (one cycle)
//   - web[hit_way]=0, data_wmask=0 except bits [4*w +: 4]=stage_reg.wmask, where w=offset[OFF_W-1:2].
//   - data_in word w = stage_reg.wdata; tag_in = stage_reg.tag; valid_in = 1.
//   - Assert write_done; go BUBBLE.
//  BUBBLE (one cycle)
//   - req_ready=0, no array write; go RUN, where stage 2 replays stage_reg.
//  Address rules
//   - ufp_addr[1:0] is ignored for word selection.
//   - tag = addr[ADDR_W-1 -: TAG_W], set = addr[OFF_W +: SET_W].
//  Reset during FILL: fill is abandoned; a dfp_resp arriving after reset is ignored.
// CONFIGURATION
//  CACHE_STAGE1_WRITE_MERGE_EN
//   - Defined: on dfp_resp in FILL with stage_reg.wmask!=0, store bytes are merged into dfp_rdata in the same write.
//   - In that case write_done pulses and FILL goes straight to BUBBLE; the replayed request then sees store_hit=0 from stage 2.
//   - Undefined: the fill writes the raw line; the store completes later via the replay -> STORE path.
// STRUCTURE
//  Package cache_types:
//   - stage1_state_t enum.
//   - stage_reg_t packed struct.
//   - Width localparams matching the defaults; the module asserts its parameters equal them at elaboration.
//  Sub-module plru_victim #(WAYS): combinational tree decode, plru_bits -> way.
// TESTING
//  1 Read miss, plru_bits=3'b100: dfp_resp with line 0xA5.. -> web=4'b1011 one cycle, BUBBLE, then req_ready=1.
//  2 Store hit: wmask=4'b0110, addr offset 0x14, hit_way=3 -> data_wmask=32'h0060_0000, web=4'b0111, write_done=1.
//  3 miss and store_hit together -> FILL taken, no STORE write until replay.
//  4 rst=0 asserted mid-FILL, then a late dfp_resp -> no web low; stage_reg=0; state=RUN.
//  5 WRITE_MERGE_EN, store miss wdata=0xDEADBEEF at word 2 -> single fill write, line word 2 = 0xDEADBEEF, write_done=1.
//  6 Back-to-back zero-mask requests -> req_ready=1 every cycle, web stays all 1.

Source files
------------

// File: rtl/cache_stage1_ctrl_pkg.sv
// Shared types and default geometry for the stage-1 cache controller.
// The optional store/fill merge is enabled by defining CACHE_STAGE1_WRITE_MERGE_EN.
package cache_types;

    localparam int CACHE_WAYS       = 4;
    localparam int CACHE_SETS       = 16;
    localparam int CACHE_LINE_BYTES = 32;
    localparam int CACHE_ADDR_W     = 32;
    localparam int CACHE_OFF_W      = $clog2(CACHE_LINE_BYTES);
    localparam int CACHE_SET_W      = $clog2(CACHE_SETS);
    localparam int CACHE_TAG_W      = CACHE_ADDR_W - CACHE_SET_W - CACHE_OFF_W;
    localparam int CACHE_WAY_W      = $clog2(CACHE_WAYS);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FILL   = 2'd1,
        S_STORE  = 2'd2,
        S_BUBBLE = 2'd3
    } stage1_state_t;

    typedef struct packed {
        logic [CACHE_ADDR_W-1:0] addr;
        logic [CACHE_TAG_W-1:0]  tag;
        logic [CACHE_SET_W-1:0]  set;
        logic [CACHE_OFF_W-1:0]  offset;
        logic [3:0]              rmask;
        logic [3:0]              wmask;
        logic [31:0]             wdata;
    } stage_reg_t;

endpackage

// File: rtl/cache_stage1_ctrl_if.sv
// Upstream request port of the stage-1 cache controller.
interface cache_stage1_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] ufp_addr;
    logic [3:0]        ufp_rmask;
    logic [3:0]        ufp_wmask;
    logic [31:0]       ufp_wdata;
    logic              req_ready;

    modport master (output ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, input req_ready);
    modport slave  (input ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, output req_ready);
endinterface

// File: rtl/cache_stage1_ctrl_plru.sv
// Tree-PLRU victim decode: walk from the root, bit==1 goes to child 2i+1, bit==0 to 2i+2.
module plru_victim #(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  plru_bits,
    output logic [WAY_W-1:0] way
);
    localparam int NODE_W = $clog2(2*WAYS-1);

    logic [2*WAYS-2:0] tree;
    logic [NODE_W-1:0] node;

    // Leaf slots are padded with zeros so the walk can index the tree uniformly.
    assign tree = {{WAYS{1'b0}}, plru_bits};

    always_comb begin
        node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            node = tree[node] ? NODE_W'(2*node + 1) : NODE_W'(2*node + 2);
        end
        way = WAY_W'(node - NODE_W'(WAYS-1));
    end
endmodule

// File: rtl/cache_stage1_ctrl.sv
// Stage-1 controller of the pipelined write-back cache: request capture, PLRU fill, store writes.
// Define CACHE_STAGE1_WRITE_MERGE_EN to merge a pending store into the fill line.
module cache_stage1_ctrl
    import cache_types::*;
#(
    parameter  int WAYS       = 4,
    parameter  int SETS       = 16,
    parameter  int LINE_BYTES = 32,
    parameter  int ADDR_W     = 32,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int SET_W      = $clog2(SETS),
    localparam int TAG_W      = ADDR_W - SET_W - OFF_W,
    localparam int WAY_W      = $clog2(WAYS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    cache_stage1_ctrl_if.slave                   ufp,
    input  logic [WAYS-2:0]                      plru_bits,
    input  logic                                 miss,
    input  logic                                 store_hit,
    input  logic [WAY_W-1:0]                     hit_way,
    input  logic [8*LINE_BYTES-1:0]              dfp_rdata,
    input  logic                                 dfp_resp,
    output logic [WAYS-1:0]                      web,
    output logic [WAYS-1:0][8*LINE_BYTES-1:0]    data_in,
    output logic [WAYS-1:0][TAG_W-1:0]           tag_in,
    output logic [WAYS-1:0]                      valid_in,
    output logic [LINE_BYTES-1:0]                data_wmask,
    output logic [WAY_W-1:0]                     victim_way,
    output logic                                 write_done,
    output stage_reg_t                           stage_reg
);
    if (WAYS != CACHE_WAYS || SETS != CACHE_SETS ||
        LINE_BYTES != CACHE_LINE_BYTES || ADDR_W != CACHE_ADDR_W) begin : g_param_check
        $error("cache_stage1_ctrl parameters must match cache_types geometry");
    end

    stage1_state_t      state, state_nxt;
    stage_reg_t         req_next;
    logic               capture, latch_victim, req_ready;
    logic [WAY_W-1:0]   plru_way;
    logic [OFF_W-3:0]   word;
    logic [8*LINE_BYTES-1:0] fill_line;

    function automatic logic [LINE_BYTES-1:0] store_mask(input logic [3:0] m, input logic [OFF_W-3:0] w);
        return {{(LINE_BYTES-4){1'b0}}, m} << {w, 2'b00};
    endfunction

    function automatic logic [8*LINE_BYTES-1:0] store_line(input logic [31:0] d, input logic [OFF_W-3:0] w);
        return {{(8*LINE_BYTES-32){1'b0}}, d} << {w, 5'b00000};
    endfunction

`ifdef CACHE_STAGE1_WRITE_MERGE_EN
    function automatic logic [8*LINE_BYTES-1:0] byte_expand(input logic [LINE_BYTES-1:0] m);
        logic [8*LINE_BYTES-1:0] r;
        for (int b = 0; b < LINE_BYTES; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction
`endif

    plru_victim #(.WAYS(WAYS), .WAY_W(WAY_W)) u_plru (
        .plru_bits (plru_bits),
        .way       (plru_way)
    );

    assign word          = stage_reg.offset[OFF_W-1:2];
    assign ufp.req_ready = req_ready;

    always_comb begin
        req_next        = '0;
        req_next.addr   = ufp.ufp_addr;
        req_next.tag    = ufp.ufp_addr[ADDR_W-1 -: TAG_W];
        req_next.set    = ufp.ufp_addr[OFF_W +: SET_W];
        req_next.offset = ufp.ufp_addr[OFF_W-1:0];
        req_next.rmask  = ufp.ufp_rmask;
        req_next.wmask  = ufp.ufp_wmask;
        req_next.wdata  = ufp.ufp_wdata;
    end

`ifdef CACHE_STAGE1_WRITE_MERGE_EN
    logic [8*LINE_BYTES-1:0] merge_bytes;
    assign merge_bytes = byte_expand(store_mask(stage_reg.wmask, word));
    assign fill_line   = (stage_reg.wmask != 4'b0)
                       ? ((dfp_rdata & ~merge_bytes) | (store_line(stage_reg.wdata, word) & merge_bytes))
                       : dfp_rdata;
`else
    assign fill_line   = dfp_rdata;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_RUN;
            stage_reg  <= '0;
            victim_way <= '0;
        end else begin
            state <= state_nxt;
            if (capture)      stage_reg  <= req_next;
            if (latch_victim) victim_way <= plru_way;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        capture      = 1'b0;
        latch_victim = 1'b0;
        web          = '1;
        data_in      = '0;
        tag_in       = '0;
        valid_in     = '0;
        data_wmask   = '1;
        write_done   = 1'b0;
        unique case (state)
            S_RUN: begin
                // miss outranks store_hit: the line must be present before any store lands.
                if (miss) begin
                    state_nxt    = S_FILL;
                    latch_victim = 1'b1;
                end else if (store_hit) begin
                    state_nxt = S_STORE;
                end else begin
                    req_ready = 1'b1;
                    capture   = 1'b1;
                end
            end
            S_FILL: begin
                if (dfp_resp) begin
                    web[victim_way] = 1'b0;
                    data_in         = {WAYS{fill_line}};
                    tag_in          = {WAYS{stage_reg.tag}};
                    valid_in        = '1;
`ifdef CACHE_STAGE1_WRITE_MERGE_EN
                    write_done      = (stage_reg.wmask != 4'b0);
`endif
                    state_nxt       = S_BUBBLE;
                end
            end
            S_STORE: begin
                web[hit_way] = 1'b0;
                data_wmask   = store_mask(stage_reg.wmask, word);
                data_in      = {WAYS{store_line(stage_reg.wdata, word)}};
                tag_in       = {WAYS{stage_reg.tag}};
                valid_in     = '1;
                write_done   = 1'b1;
                state_nxt    = S_BUBBLE;
            end
            S_BUBBLE: state_nxt = S_RUN;
            default:  state_nxt = S_RUN;
        endcase
    end
endmodule

// File: tb/tb_cache_stage1_ctrl.sv
// Scoreboard bench for cache_stage1_ctrl: expected array writes are queued by the driver, popped by a monitor.
module tb_cache_stage1_ctrl;
    import cache_types::*;

    localparam int WAYS  = 4;
    localparam int LB    = 32;
    localparam int LW    = 8*LB;
    localparam int TAG_W = 23;
    localparam int WAY_W = 2;
`ifdef CACHE_STAGE1_WRITE_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_stage1_ctrl_if #(.ADDR_W(32)) ufp_if ();

    logic [WAYS-2:0]            plru_bits;
    logic                       miss, store_hit, dfp_resp;
    logic [WAY_W-1:0]           hit_way;
    logic [LW-1:0]              dfp_rdata;
    logic [WAYS-1:0]            web;
    logic [WAYS-1:0][LW-1:0]    data_in;
    logic [WAYS-1:0][TAG_W-1:0] tag_in;
    logic [WAYS-1:0]            valid_in;
    logic [LB-1:0]              data_wmask;
    logic [WAY_W-1:0]           victim_way;
    logic                       write_done;
    stage_reg_t                 stage_reg;

    cache_stage1_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ufp        (ufp_if),
        .plru_bits  (plru_bits),
        .miss       (miss),
        .store_hit  (store_hit),
        .hit_way    (hit_way),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .web        (web),
        .data_in    (data_in),
        .tag_in     (tag_in),
        .valid_in   (valid_in),
        .data_wmask (data_wmask),
        .victim_way (victim_way),
        .write_done (write_done),
        .stage_reg  (stage_reg)
    );

    typedef struct {
        logic [WAYS-1:0]  web;
        logic [LB-1:0]    wmask;
        logic [LW-1:0]    data;
        logic [TAG_W-1:0] tag;
        logic             done;
        logic [WAY_W-1:0] way;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int victim(input logic [WAYS-2:0] b);
        int n = 0;
        while (n < WAYS-1) n = b[n] ? 2*n + 1 : 2*n + 2;
        return n - (WAYS-1);
    endfunction

    function automatic logic [LW-1:0] expand(input logic [LB-1:0] m);
        logic [LW-1:0] r = '0;
        for (int b = 0; b < LB; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [LB-1:0] smask(input logic [31:0] a, input logic [3:0] m);
        logic [LB-1:0] r = '0;
        int w = int'(a[4:2]);
        for (int b = 0; b < 4; b++) r[4*w + b] = m[b];
        return r;
    endfunction

    function automatic logic [LW-1:0] sdata(input logic [31:0] a, input logic [31:0] d);
        logic [LW-1:0] r = '0;
        r[32*int'(a[4:2]) +: 32] = d;
        return r;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: any array write or write_done pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst && (web !== '1 || write_done !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: web=%b write_done=%b, no write expected", web, write_done);
            end else begin
                e = exp_q.pop_front();
                chk("web", LW'(web), LW'(e.web));
                chk("data_wmask", LW'(data_wmask), LW'(e.wmask));
                chk("write_done", LW'(write_done), LW'(e.done));
                chk("tag_in", LW'(tag_in[e.way]), LW'(e.tag));
                chk("valid_in", LW'(valid_in[e.way]), LW'(1'b1));
                chk("data_in", data_in[e.way] & expand(e.wmask), e.data & expand(e.wmask));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, input int way);
        wr_t e;
        e.web   = ~(WAYS'(1) << way);
        e.wmask = smask(a, m);
        e.data  = sdata(a, d);
        e.tag   = a[31:9];
        e.done  = 1'b1;
        e.way   = WAY_W'(way);
        exp_q.push_back(e);
    endtask

    task automatic push_fill(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                             input int way, input logic [LW-1:0] line);
        wr_t e;
        logic [LW-1:0] bm;
        bm      = expand(smask(a, m));
        e.web   = ~(WAYS'(1) << way);
        e.wmask = '1;
        e.data  = (MERGE && m != 4'b0) ? ((line & ~bm) | (sdata(a, d) & bm)) : line;
        e.tag   = a[31:9];
        e.done  = MERGE && (m != 4'b0);
        e.way   = WAY_W'(way);
        exp_q.push_back(e);
    endtask

    // kind: 0 read hit / idle, 1 store hit, 2 miss, 3 miss together with store_hit
    task automatic txn(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input int kind_in, input logic [WAYS-2:0] plru,
                       input logic [WAY_W-1:0] hway, input logic [LW-1:0] line,
                       input int delay, input bit stray);
        int kind = kind_in;
        int v;
        ufp_if.ufp_addr  = addr;
        ufp_if.ufp_rmask = rm;
        ufp_if.ufp_wmask = wm;
        ufp_if.ufp_wdata = wd;
        miss      = 1'b0;
        store_hit = 1'b0;
        dfp_resp  = stray;
        dfp_rdata = rand_line();
        #1 chk("req_ready_run", LW'(ufp_if.req_ready), LW'(1'b1));
        cyc();
        dfp_resp = 1'b0;
        chk("stage_addr", LW'(stage_reg.addr), LW'(addr));
        chk("stage_tag", LW'(stage_reg.tag), LW'(addr[31:9]));
        chk("stage_set", LW'(stage_reg.set), LW'(addr[8:5]));
        chk("stage_offset", LW'(stage_reg.offset), LW'(addr[4:0]));
        chk("stage_masks", LW'({stage_reg.rmask, stage_reg.wmask}), LW'({rm, wm}));
        chk("stage_wdata", LW'(stage_reg.wdata), LW'(wd));
        ufp_if.ufp_addr  = $urandom;
        ufp_if.ufp_rmask = 4'b0;
        ufp_if.ufp_wmask = 4'b0;
        if (kind == 1 && wm == 4'b0) kind = 0;
        if (kind == 1) begin
            store_hit = 1'b1;
            hit_way   = hway;
            push_store(addr, wm, wd, int'(hway));
            #1 chk("req_ready_store_hit", LW'(ufp_if.req_ready), LW'(1'b0));
            cyc();
            store_hit = 1'b0;
            cyc();
            chk("req_ready_bubble", LW'(ufp_if.req_ready), LW'(1'b0));
            cyc();
        end else if (kind >= 2) begin
            miss      = 1'b1;
            store_hit = (kind == 3);
            hit_way   = hway;
            plru_bits = plru;
            #1 chk("req_ready_miss", LW'(ufp_if.req_ready), LW'(1'b0));
            cyc();
            miss      = 1'b0;
            store_hit = 1'b0;
            v = victim(plru);
            chk("victim_way", LW'(victim_way), LW'(v));
            ufp_if.ufp_rmask = 4'hF;
            ufp_if.ufp_wmask = 4'hF;
            repeat (delay) begin
                chk("req_ready_fill", LW'(ufp_if.req_ready), LW'(1'b0));
                cyc();
            end
            dfp_resp  = 1'b1;
            dfp_rdata = line;
            push_fill(addr, wm, wd, v, line);
            cyc();
            dfp_resp = 1'b0;
            chk("req_ready_bubble", LW'(ufp_if.req_ready), LW'(1'b0));
            ufp_if.ufp_rmask = 4'b0;
            ufp_if.ufp_wmask = 4'b0;
            cyc();
            chk("stage_hold_after_fill", LW'(stage_reg.addr), LW'(addr));
            if (wm != 4'b0 && !MERGE) begin
                store_hit = 1'b1;
                hit_way   = WAY_W'(v);
                push_store(addr, wm, wd, v);
                cyc();
                store_hit = 1'b0;
                cyc();
                cyc();
            end
        end
    endtask

    initial begin : timeout
        #500000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [LW-1:0] a5_line;
        logic [3:0]    wm;
        ufp_if.ufp_addr  = '0;
        ufp_if.ufp_rmask = '0;
        ufp_if.ufp_wmask = '0;
        ufp_if.ufp_wdata = '0;
        plru_bits = '0;
        miss      = 1'b0;
        store_hit = 1'b0;
        hit_way   = '0;
        dfp_rdata = '0;
        dfp_resp  = 1'b0;
        #1;
        chk("reset_stage_reg", LW'(stage_reg), '0);
        chk("reset_web", LW'(web), LW'(4'hF));
        chk("reset_data_wmask", LW'(data_wmask), LW'(32'hFFFF_FFFF));
        chk("reset_write_done", LW'(write_done), '0);
        chk("reset_victim", LW'(victim_way), '0);
        chk("reset_data_in", data_in[0] | data_in[3], '0);
        chk("reset_tag_valid", LW'({tag_in, valid_in}), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cyc();

        // Read miss into the way chosen by plru_bits=3'b100
        for (int i = 0; i < LB; i++) a5_line[8*i +: 8] = 8'hA5;
        txn(32'h1234_5608, 4'hF, 4'h0, 32'h0, 2, 3'b100, 2'd0, a5_line, 2, 1'b0);
        // Store hit, offset 0x14, bytes 1..2, way 3
        txn(32'hCAFE_0014, 4'h0, 4'b0110, 32'h1122_3344, 1, 3'b000, 2'd3, '0, 0, 1'b0);
        // miss and store_hit together: fill first, store only on replay
        txn(32'h0000_1A24, 4'h0, 4'b1111, 32'h5566_7788, 3, 3'b011, 2'd1, rand_line(), 1, 1'b0);
        // Store miss at word 2
        txn(32'h8000_0048, 4'h0, 4'hF, 32'hDEAD_BEEF, 2, 3'b010, 2'd0, rand_line(), 0, 1'b0);

        // Reset asserted mid-fill, then a late dfp_resp
        txn(32'h7777_7000, 4'hF, 4'h0, 32'h0, 0, 3'b000, 2'd0, '0, 0, 1'b0);
        ufp_if.ufp_addr = 32'h4444_4440;
        ufp_if.ufp_rmask = 4'hF;
        cyc();
        miss      = 1'b1;
        plru_bits = 3'b100;
        cyc();
        miss = 1'b0;
        chk("victim_before_reset", LW'(victim_way), LW'(2));
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("rst_fill_stage_reg", LW'(stage_reg), '0);
        chk("rst_fill_victim", LW'(victim_way), '0);
        chk("rst_fill_web", LW'(web), LW'(4'hF));
        chk("rst_fill_req_ready", LW'(ufp_if.req_ready), LW'(1'b1));
        cyc();
        rst = 1'b1;
        ufp_if.ufp_rmask = 4'h0;
        cyc();
        dfp_resp  = 1'b1;
        dfp_rdata = rand_line();
        #1 chk("late_dfp_web", LW'(web), LW'(4'hF));
        cyc();
        dfp_resp = 1'b0;

        // Back-to-back idle requests
        for (int i = 0; i < 6; i++) begin
            ufp_if.ufp_addr  = $urandom;
            ufp_if.ufp_rmask = 4'h0;
            ufp_if.ufp_wmask = 4'h0;
            #1;
            chk("idle_req_ready", LW'(ufp_if.req_ready), LW'(1'b1));
            chk("idle_web", LW'(web), LW'(4'hF));
            cyc();
            chk("idle_capture", LW'(stage_reg.addr), LW'(ufp_if.ufp_addr));
        end

        for (int i = 0; i < 80; i++) begin
            wm = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            txn($urandom, 4'($urandom), wm, $urandom, $urandom_range(0, 3),
                3'($urandom), 2'($urandom), rand_line(), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0));
        end

        cyc();
        chk("pending_writes", LW'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
